if1_if2: RTL and testbench

- Pipeline boundary between IF1 (ICache response stage) and IF2 (predecode / instruction-buffer stage).
- Captures the fetched PC, next PC, the 64-bit ICache fetch word and fetch exception per fetch group.
- Derives a 2-bit slot mask from PC alignment.
- Contains a 2-entry skid buffer (main + skid) so `if1_ready` is a registered signal, breaking the IF2→IF0 ready path.

---
 rtl/if1_if2.sv | 160 ++++++++++++++++
 tb/tb_if1_if2.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if1_if2.sv
// ============================================================================
// Module   : if1_if2
// Brief    : IF1 -> IF2 fetch pipeline boundary with a 2-entry (main + skid)
//            buffer so if1_ready comes straight from a flop. Optional perf
//            counters are enabled by defining IF1_IF2_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if1_if2 #(
  parameter int          EXCP_W   = 7,
  parameter logic [31:0] PC_RESET = 32'h1c00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if1_valid,
  output logic              if1_ready,
  output logic              if2_valid,
  input  logic              if2_ready,
  input  logic              flush,
  input  logic [31:0]       if1_pc,
  input  logic [31:0]       if1_pc_next,
  input  logic [63:0]       if1_rdata,
  input  logic              if1_excp,
  input  logic [EXCP_W-1:0] if1_excp_code,
  output logic [31:0]       if2_pc,
  output logic [31:0]       if2_pc_next,
  output logic [31:0]       if2_inst0,
  output logic [31:0]       if2_inst1,
  output logic [1:0]        if2_mask,
  output logic              if2_excp,
  output logic [EXCP_W-1:0] if2_excp_code
`ifdef IF1_IF2_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic [31:0]       inst0;
    logic [31:0]       inst1;
    logic [1:0]        mask;
    logic              excp;
    logic [EXCP_W-1:0] code;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{PC_RESET, PC_RESET + 32'd8, 32'd0, 32'd0,
                                     2'b00, 1'b0, {EXCP_W{1'b0}}};

  // Bit 0 is the main-valid flop, bit 1 the skid-valid flop.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_entry;
  logic   accept, drain, load_main, load_skid, promote;

  assign if1_ready = ~state[1];
  assign if2_valid = state[0];
  assign accept    = if1_valid & if1_ready;
  assign drain     = if2_valid & if2_ready;

  // A faulting group keeps only the slot the PC points at, with no payload.
  always_comb begin
    in_entry         = RESET_ENTRY;
    in_entry.pc      = if1_pc;
    in_entry.pc_next = if1_pc_next;
    in_entry.excp    = if1_excp;
    in_entry.code    = if1_excp_code;
    if (if1_excp) begin
      in_entry.mask  = if1_pc[2] ? 2'b10 : 2'b01;
      in_entry.inst0 = 32'd0;
      in_entry.inst1 = 32'd0;
    end else begin
      in_entry.mask  = if1_pc[2] ? 2'b10 : 2'b11;
      in_entry.inst0 = if1_rdata[31:0];
      in_entry.inst1 = if1_rdata[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (drain) begin
          promote   = 1'b1;
          state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_ENTRY;
      skid_q <= RESET_ENTRY;
    end else if (flush) begin
      main_q <= RESET_ENTRY;
      skid_q <= RESET_ENTRY;
    end else begin
      if (load_main)    main_q <= in_entry;
      else if (promote) main_q <= skid_q;
      if (load_skid)    skid_q <= in_entry;
    end
  end

  assign if2_pc        = main_q.pc;
  assign if2_pc_next   = main_q.pc_next;
  assign if2_inst0     = main_q.inst0;
  assign if2_inst1     = main_q.inst1;
  assign if2_mask      = main_q.mask;
  assign if2_excp      = main_q.excp;
  assign if2_excp_code = main_q.code;

`ifdef IF1_IF2_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt <= 32'd0;
      perf_stall_cnt  <= 32'd0;
    end else begin
      if (if2_ready && !if2_valid && !flush) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (if1_valid && !if1_ready)           perf_stall_cnt  <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if1_if2.sv
// Self-checking bench for if1_if2: directed scenarios plus a randomized run
// against a queue-based model of the two-deep buffer.
`default_nettype none

module tb_if1_if2;
  localparam int          EXCP_W   = 7;
  localparam logic [31:0] PC_RESET = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic [31:0]       inst0;
    logic [31:0]       inst1;
    logic [1:0]        mask;
    logic              excp;
    logic [EXCP_W-1:0] code;
  } ent_t;

  logic clk = 1'b0, rst = 1'b1;
  logic if1_valid = 0, if2_ready = 0, flush = 0, if1_excp = 0;
  logic if1_ready, if2_valid, if2_excp;
  logic [31:0] if1_pc = 0, if1_pc_next = 0;
  logic [63:0] if1_rdata = 0;
  logic [EXCP_W-1:0] if1_excp_code = 0, if2_excp_code;
  logic [31:0] if2_pc, if2_pc_next, if2_inst0, if2_inst1;
  logic [1:0]  if2_mask;
`ifdef IF1_IF2_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  if1_if2 #(.EXCP_W(EXCP_W), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst),
    .if1_valid(if1_valid), .if1_ready(if1_ready),
    .if2_valid(if2_valid), .if2_ready(if2_ready), .flush(flush),
    .if1_pc(if1_pc), .if1_pc_next(if1_pc_next), .if1_rdata(if1_rdata),
    .if1_excp(if1_excp), .if1_excp_code(if1_excp_code),
    .if2_pc(if2_pc), .if2_pc_next(if2_pc_next),
    .if2_inst0(if2_inst0), .if2_inst1(if2_inst1), .if2_mask(if2_mask),
    .if2_excp(if2_excp), .if2_excp_code(if2_excp_code)
`ifdef IF1_IF2_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  function automatic ent_t make_entry(logic [31:0] pc, logic [31:0] pcn,
                                      logic [63:0] data, logic ex, logic [EXCP_W-1:0] code);
    ent_t e;
    e.pc = pc; e.pc_next = pcn; e.excp = ex; e.code = code;
    if (ex) begin
      e.inst0 = 32'd0; e.inst1 = 32'd0;
      e.mask  = (pc[2] == 1'b1) ? 2'b10 : 2'b01;
    end else begin
      e.inst0 = data[31:0]; e.inst1 = data[63:32];
      e.mask  = (pc[2] == 1'b1) ? 2'b10 : 2'b11;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(logic [31:0] pc);
    if1_valid = 1; if1_pc = pc; if1_pc_next = pc + 32'd8;
    if1_rdata = {~pc, pc}; if1_excp = 0; if1_excp_code = '0;
  endtask

  task automatic idle();
    if1_valid = 0; flush = 0; if1_excp = 0; if1_excp_code = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); if2_ready = 0;
    tick(); tick();
    total++; if (if2_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if2_valid); end
    total++; if (if1_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", if1_ready); end
    total++; if ({if2_pc, if2_pc_next, if2_mask, if2_inst0, if2_inst1, if2_excp, if2_excp_code}
                 !== {PC_RESET, PC_RESET + 32'd8, 2'b00, 64'd0, 1'b0, {EXCP_W{1'b0}}}) begin
      bad++; $display("FAIL reset_outputs got pc=%h pcn=%h mask=%b exp pc=%h pcn=%h mask=00",
                      if2_pc, if2_pc_next, if2_mask, PC_RESET, PC_RESET + 32'd8);
    end
    @(negedge clk); rst = 0; tick();
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h1c00_0000; pcs[1] = 32'h1c00_0008; pcs[2] = 32'h1c00_0010;
    if2_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(pcs[i]); tick();
      total++; if (!(if2_valid === 1'b1 && if2_pc === pcs[i] && if2_mask === 2'b11 && if1_ready === 1'b1)) begin
        bad++; $display("FAIL stream_%0d got v=%b pc=%h mask=%b rdy=%b exp v=1 pc=%h mask=11 rdy=1",
                        i, if2_valid, if2_pc, if2_mask, if1_ready, pcs[i]);
      end
    end
    idle(); tick();
    total++; if (if2_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", if2_valid); end
  endtask

  task automatic test_skid_fill();
    if2_ready = 0;
    send(32'h1c00_0000); tick();
    send(32'h1c00_0008); tick();
    idle(); tick();
    total++; if (!(if1_ready === 1'b0 && if2_valid === 1'b1 && if2_pc === 32'h1c00_0000)) begin
      bad++; $display("FAIL skid_full got rdy=%b v=%b pc=%h exp rdy=0 v=1 pc=1c000000", if1_ready, if2_valid, if2_pc);
    end
    if2_ready = 1; tick();
    total++; if (!(if1_ready === 1'b1 && if2_valid === 1'b1 && if2_pc === 32'h1c00_0008)) begin
      bad++; $display("FAIL skid_drain1 got rdy=%b v=%b pc=%h exp rdy=1 v=1 pc=1c000008", if1_ready, if2_valid, if2_pc);
    end
    tick();
    total++; if (if2_valid !== 1'b0) begin bad++; $display("FAIL skid_drain2 got v=%b exp 0", if2_valid); end
  endtask

  task automatic test_odd_pc();
    if2_ready = 1;
    send(32'h1c00_0004); if1_rdata = 64'hAAAAAAAA_BBBBBBBB; tick();
    total++; if (!(if2_mask === 2'b10 && if2_inst1 === 32'hAAAAAAAA && if2_inst0 === 32'hBBBBBBBB)) begin
      bad++; $display("FAIL odd_pc got mask=%b i1=%h i0=%h exp mask=10 i1=aaaaaaaa i0=bbbbbbbb", if2_mask, if2_inst1, if2_inst0);
    end
    idle(); tick();
  endtask

  task automatic test_exception();
    if2_ready = 1;
    send(32'h1c00_0000); if1_excp = 1; if1_excp_code = 7'h08; if1_rdata = 64'h1234_5678_9abc_def0; tick();
    total++; if (!(if2_excp === 1'b1 && if2_excp_code === 7'h08 && if2_mask === 2'b01 &&
                   if2_inst0 === 32'd0 && if2_inst1 === 32'd0)) begin
      bad++; $display("FAIL excp got ex=%b code=%h mask=%b i0=%h i1=%h exp ex=1 code=08 mask=01 insts=0",
                      if2_excp, if2_excp_code, if2_mask, if2_inst0, if2_inst1);
    end
    idle(); tick();
  endtask

  task automatic test_flush_full();
    if2_ready = 0;
    send(32'h1c00_0000); tick();
    send(32'h1c00_0008); tick();
    send(32'h1c00_0100); flush = 1; tick();
    total++; if (!(if2_valid === 1'b0 && if1_ready === 1'b1 && if2_pc === PC_RESET && if2_mask === 2'b00)) begin
      bad++; $display("FAIL flush got v=%b rdy=%b pc=%h mask=%b exp v=0 rdy=1 pc=%h mask=00",
                      if2_valid, if1_ready, if2_pc, if2_mask, PC_RESET);
    end
    idle(); if2_ready = 1; tick(); tick();
    total++; if (if2_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got v=%b exp 0", if2_valid); end
  endtask

  task automatic test_async_reset();
    if2_ready = 0;
    send(32'h1c00_0040); tick(); idle();
    #2 rst = 1; #1;
    total++; if (!(if2_valid === 1'b0 && if1_ready === 1'b1 && if2_pc === PC_RESET)) begin
      bad++; $display("FAIL async_reset got v=%b rdy=%b pc=%h exp v=0 rdy=1 pc=%h", if2_valid, if1_ready, if2_pc, PC_RESET);
    end
    @(negedge clk); rst = 0; tick();
  endtask

  task automatic test_random();
    ent_t exp_e, got_e;
    bit clean, acc, dr, rdy;
    int bub, stl;
    rst = 1; idle(); if2_ready = 0; tick(); @(negedge clk); rst = 0; tick();
    q.delete(); clean = 1; bub = 0; stl = 0;
    for (int n = 0; n < 600; n++) begin
      got_e = '{if2_pc, if2_pc_next, if2_inst0, if2_inst1, if2_mask, if2_excp, if2_excp_code};
      total++; if (!(if2_valid === (q.size() != 0) && if1_ready === (q.size() < 2))) begin
        bad++; $display("FAIL rand_hs cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b", n, if2_valid, if1_ready, q.size() != 0, q.size() < 2);
      end
      if (q.size() != 0) exp_e = q[0];
      else if (clean)    exp_e = '{PC_RESET, PC_RESET + 32'd8, 32'd0, 32'd0, 2'b00, 1'b0, {EXCP_W{1'b0}}};
      if (q.size() != 0 || clean) begin
        total++; if (got_e !== exp_e) begin
          bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", n, got_e, exp_e);
        end
      end
`ifdef IF1_IF2_PERF_EN
      total++; if (perf_bubble_cnt !== bub || perf_stall_cnt !== stl) begin
        bad++; $display("FAIL rand_perf cyc=%0d got b=%0d s=%0d exp b=%0d s=%0d", n, perf_bubble_cnt, perf_stall_cnt, bub, stl);
      end
`endif
      if1_valid = ($urandom_range(0, 3) != 0);
      if2_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      if1_pc    = 32'h1c00_0000 + ($urandom_range(0, 1023) << 2);
      if1_pc_next = $urandom;
      if1_rdata = {$urandom, $urandom};
      if1_excp  = ($urandom_range(0, 7) == 0);
      if1_excp_code = EXCP_W'($urandom);
      rdy = (q.size() < 2);
      acc = if1_valid && rdy;
      dr  = (q.size() != 0) && if2_ready;
      if (if2_ready && q.size() == 0 && !flush) bub++;
      if (if1_valid && !rdy) stl++;
      if (flush) begin
        q.delete(); clean = 1;
      end else begin
        if (dr) void'(q.pop_front());
        if (acc) begin
          q.push_back(make_entry(if1_pc, if1_pc_next, if1_rdata, if1_excp, if1_excp_code));
          clean = 0;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_fill();
    test_odd_pc();
    test_exception();
    test_flush_full();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
